alu_op_issuer: RTL and testbench

Command-issue and result-capture stage placed directly upstream of the 16-bit `ALU_TOP`. Buffers operand/opcode commands from a valid/ready producer in a small FIFO and drives `A`/`B`/`ALU_FUN` one command at a time. Waits out the ALU's registered latency, then selects the active unit's output using the opcode and unit flags. Presents the result on a valid/ready result port.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_cmd_fifo.sv | 53 +++++
 rtl/alu_op_issuer.sv | 156 +++++++++++++++
 tb/tb_alu_op_issuer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, unit/state enums and flag helpers for the ALU
// command issuer.
package alu_pkg;

  localparam logic [3:0] FUN_ADD    = 4'b0000;
  localparam logic [3:0] FUN_SUB    = 4'b0001;
  localparam logic [3:0] FUN_MUL    = 4'b0010;
  localparam logic [3:0] FUN_DIV    = 4'b0011;
  localparam logic [3:0] FUN_AND    = 4'b0100;
  localparam logic [3:0] FUN_OR     = 4'b0101;
  localparam logic [3:0] FUN_NAND   = 4'b0110;
  localparam logic [3:0] FUN_NOR    = 4'b0111;
  localparam logic [3:0] FUN_CMP_NO = 4'b1000;
  localparam logic [3:0] FUN_CMP_EQ = 4'b1001;
  localparam logic [3:0] FUN_CMP_GT = 4'b1010;
  localparam logic [3:0] FUN_CMP_LT = 4'b1011;
  localparam logic [3:0] FUN_SHR_A  = 4'b1100;
  localparam logic [3:0] FUN_SHL_A  = 4'b1101;
  localparam logic [3:0] FUN_SHR_B  = 4'b1110;
  localparam logic [3:0] FUN_SHL_B  = 4'b1111;

  // Idle drive for the ALU: a compare no-op produces no side effects.
  localparam logic [3:0] FUN_NOP    = 4'b1000;

  typedef enum logic [1:0] {
    ARITH = 2'b00,
    LOGIC = 2'b01,
    CMP   = 2'b10,
    SHIFT = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    HOLD  = 2'b10
  } state_e;

  function automatic unit_e unit_of(input logic [3:0] fun);
    return unit_e'(fun[3:2]);
  endfunction

  // Flag vector ordering is {shift, cmp, logic, arith}.
  function automatic logic [3:0] unit_flag_mask(input unit_e unit);
    return 4'b0001 << unit;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH and an occupancy
// counter separates full from empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues queued commands to a registered-latency ALU and holds the selected
// unit result on a valid/ready port. Define ALU_ISSUER_ERRCHK_EN for unit-flag checking.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [WIDTH-1:0]   CMD_A,
  input  logic [WIDTH-1:0]   CMD_B,
  input  logic [3:0]         CMD_FUN,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  output logic [3:0]         ALU_FUN,
  input  logic [2*WIDTH-1:0] ARITH_OUT,
  input  logic [2*WIDTH-1:0] LOGIC_OUT,
  input  logic [2*WIDTH-1:0] CMP_OUT,
  input  logic [2*WIDTH-1:0] SHIFT_OUT,
  input  logic               CARRY_OUT,
  input  logic               ARITH_FLAG,
  input  logic               LOGIC_FLAG,
  input  logic               CMP_FLAG,
  input  logic               SHIFT_FLAG,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [2*WIDTH-1:0] RES_DATA,
  output logic               RES_CARRY,
  output logic [3:0]         RES_FUN,
  output logic               RES_ERR
);

  localparam int CW   = 2*WIDTH + 4;
  localparam int CNTW = $clog2(ALU_LAT + 1) + 1;

  logic [CW-1:0]      head;
  logic               full;
  logic               empty;
  state_e             state;
  state_e             next_state;
  logic [CNTW-1:0]    wait_cnt;
  logic               last_wait;
  logic               load;
  logic               capture;
  logic               res_take;
  unit_e              cur_unit;
  logic [2*WIDTH-1:0] sel_data;

  alu_cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .push    (CMD_VALID),
    .pop     (capture),
    .wr_data ({CMD_FUN, CMD_A, CMD_B}),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Ready is forced low while reset is asserted, not just once the FIFO clears.
  assign CMD_READY = RST && !full;
  assign last_wait = (wait_cnt == CNTW'(ALU_LAT));
  assign cur_unit  = unit_of(ALU_FUN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty)               next_state = ISSUE;
      ISSUE:   if (last_wait)            next_state = HOLD;
      HOLD:    if (RES_VALID && RES_READY) next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    capture  = 1'b0;
    res_take = 1'b0;
    case (state)
      IDLE:    load     = !empty;
      ISSUE:   capture  = last_wait;
      HOLD:    res_take = RES_VALID && RES_READY;
      default: ;
    endcase
  end

  always_comb begin
    case (cur_unit)
      ARITH:   sel_data = ARITH_OUT;
      LOGIC:   sel_data = LOGIC_OUT;
      CMP:     sel_data = CMP_OUT;
      default: sel_data = SHIFT_OUT;
    endcase
  end

  // ALU operands stay on the bus until capture, then fall back to the no-op.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= FUN_NOP;
      wait_cnt <= '0;
    end else if (load) begin
      ALU_FUN  <= head[CW-1 -: 4];
      ALU_A    <= head[2*WIDTH-1 -: WIDTH];
      ALU_B    <= head[WIDTH-1:0];
      wait_cnt <= '0;
    end else if (capture) begin
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= FUN_NOP;
    end else if (state == ISSUE) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_CARRY <= 1'b0;
      RES_FUN   <= '0;
    end else if (capture) begin
      RES_VALID <= 1'b1;
      RES_DATA  <= sel_data;
      RES_CARRY <= (cur_unit == ARITH) && CARRY_OUT;
      RES_FUN   <= ALU_FUN;
    end else if (res_take) begin
      RES_VALID <= 1'b0;
    end
  end

`ifdef ALU_ISSUER_ERRCHK_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES_ERR <= 1'b0;
    end else if (capture) begin
      RES_ERR <= ({SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG} != unit_flag_mask(cur_unit));
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG};
  assign RES_ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer against a one-cycle-latency ALU stub.
module tb_alu_op_issuer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_fun;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_fun;
  logic [31:0] arith_out;
  logic [31:0] logic_out;
  logic [31:0] cmp_out;
  logic [31:0] shift_out;
  logic        carry_out;
  logic        arith_flag;
  logic        logic_flag_q;
  logic        logic_flag;
  logic        cmp_flag;
  logic        shift_flag;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_carry;
  logic [3:0]  res_fun;
  logic        res_err;
  logic        force_logic_flag;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_arith;
  logic [31:0] m_logic;
  logic [31:0] m_cmp;
  logic [31:0] m_shift;
  logic        m_carry;
  logic [16:0] m_wide;

  alu_op_issuer dut (
    .CLK        (clk),
    .RST        (rst_n),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .CMD_A      (cmd_a),
    .CMD_B      (cmd_b),
    .CMD_FUN    (cmd_fun),
    .ALU_A      (alu_a),
    .ALU_B      (alu_b),
    .ALU_FUN    (alu_fun),
    .ARITH_OUT  (arith_out),
    .LOGIC_OUT  (logic_out),
    .CMP_OUT    (cmp_out),
    .SHIFT_OUT  (shift_out),
    .CARRY_OUT  (carry_out),
    .ARITH_FLAG (arith_flag),
    .LOGIC_FLAG (logic_flag),
    .CMP_FLAG   (cmp_flag),
    .SHIFT_FLAG (shift_flag),
    .RES_VALID  (res_valid),
    .RES_READY  (res_ready),
    .RES_DATA   (res_data),
    .RES_CARRY  (res_carry),
    .RES_FUN    (res_fun),
    .RES_ERR    (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry is deliberately high outside arith ops so leakage into RES_CARRY shows up.
  always_comb begin
    m_arith = '0;
    m_logic = '0;
    m_cmp   = '0;
    m_shift = '0;
    m_carry = 1'b1;
    m_wide  = '0;
    case (alu_fun)
      4'b0000: begin m_wide = {1'b0, alu_a} + {1'b0, alu_b}; m_arith = {16'h0, m_wide[15:0]}; m_carry = m_wide[16]; end
      4'b0001: begin m_wide = {1'b0, alu_a} - {1'b0, alu_b}; m_arith = {16'h0, m_wide[15:0]}; m_carry = m_wide[16]; end
      4'b0010: begin m_arith = 32'(alu_a) * 32'(alu_b); m_carry = 1'b0; end
      4'b0011: begin m_arith = (alu_b == 16'h0) ? 32'h0 : 32'(alu_a / alu_b); m_carry = 1'b0; end
      4'b0100: m_logic = {16'h0, alu_a & alu_b};
      4'b0101: m_logic = {16'h0, alu_a | alu_b};
      4'b0110: m_logic = {16'h0, ~(alu_a & alu_b)};
      4'b0111: m_logic = {16'h0, ~(alu_a | alu_b)};
      4'b1001: m_cmp   = (alu_a == alu_b) ? 32'd1 : 32'd0;
      4'b1010: m_cmp   = (alu_a >  alu_b) ? 32'd2 : 32'd0;
      4'b1011: m_cmp   = (alu_a <  alu_b) ? 32'd3 : 32'd0;
      4'b1100: m_shift = {16'h0, alu_a >> 1};
      4'b1101: m_shift = {16'h0, alu_a << 1};
      4'b1110: m_shift = {16'h0, alu_b >> 1};
      4'b1111: m_shift = {16'h0, alu_b << 1};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    arith_out    <= m_arith;
    logic_out    <= m_logic;
    cmp_out      <= m_cmp;
    shift_out    <= m_shift;
    carry_out    <= m_carry;
    arith_flag   <= (alu_fun[3:2] == 2'b00);
    logic_flag_q <= (alu_fun[3:2] == 2'b01);
    cmp_flag     <= (alu_fun[3:2] == 2'b10);
    shift_flag   <= (alu_fun[3:2] == 2'b11);
  end

  assign logic_flag = logic_flag_q | force_logic_flag;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    cmd_valid = valid;
    cmd_a     = a;
    cmd_b     = b;
    cmd_fun   = fun;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitResult(input int budget);
    for (int i = 0; i < budget && !res_valid; i++) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_data [5];
    logic [3:0]  exp_fun  [5];
    logic        exp_err;
    int          got;
    int          extra;

    exp_data = '{32'd50, 32'd1, 32'd3, 32'd52, 32'h0000000A};
    exp_fun  = '{4'b0011, 4'b1001, 4'b1011, 4'b1101, 4'b0100};

    force_logic_flag = 1'b0;
    res_ready        = 1'b0;
    rst_n            = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);

    tick();
    tick();
    checkOutput("ready_in_reset", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("rst_alu_fun", 32'(alu_fun), 32'h8);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", res_data, 32'd0);
    checkOutput("rst_res_carry", 32'(res_carry), 32'd0);
    checkOutput("rst_res_fun", 32'(res_fun), 32'd0);
    checkOutput("rst_res_err", 32'(res_err), 32'd0);

    // FFFF + 1 wraps to zero with carry; walk the edge-by-edge latency.
    res_ready = 1'b1;
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
    checkOutput("add_e0_alu_fun", 32'(alu_fun), 32'h8);
    tick();
    checkOutput("add_e1_alu_a", 32'(alu_a), 32'hFFFF);
    checkOutput("add_e1_alu_b", 32'(alu_b), 32'h0001);
    checkOutput("add_e1_alu_fun", 32'(alu_fun), 32'h0);
    tick();
    checkOutput("add_e2_valid", 32'(res_valid), 32'd0);
    tick();
    checkOutput("add_e3_valid", 32'(res_valid), 32'd1);
    checkOutput("add_e3_data", res_data, 32'd0);
    checkOutput("add_e3_carry", 32'(res_carry), 32'd1);
    checkOutput("add_e3_fun", 32'(res_fun), 32'h0);
    checkOutput("add_e3_err", 32'(res_err), 32'd0);
    checkOutput("add_e3_alu_nop", 32'(alu_fun), 32'h8);
    tick();
    checkOutput("add_e4_valid", 32'(res_valid), 32'd0);

    // The first command leaves the FIFO at its capture edge, so five pushes fill four slots.
    res_ready = 1'b0;
    applyStimulus(1'b1, 16'd500, 16'd10, 4'b0011);
    tick();
    applyStimulus(1'b1, 16'd10, 16'd10, 4'b1001);
    tick();
    applyStimulus(1'b1, 16'd9, 16'd10, 4'b1011);
    tick();
    applyStimulus(1'b1, 16'b11010, 16'd0, 4'b1101);
    tick();
    checkOutput("burst_first_valid", 32'(res_valid), 32'd1);
    applyStimulus(1'b1, 16'b1010, 16'b1111, 4'b0100);
    tick();
    checkOutput("burst_full", 32'(cmd_ready), 32'd0);
    applyStimulus(1'b1, 16'd1, 16'd1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_ready", 32'(cmd_ready), 32'd0);
      checkOutput("hold_valid", 32'(res_valid), 32'd1);
      checkOutput("hold_data", res_data, 32'd50);
      checkOutput("hold_fun", 32'(res_fun), 32'h3);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);

    res_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      if (res_valid) begin
        checkOutput("drain_data", res_data, exp_data[got]);
        checkOutput("drain_fun", 32'(res_fun), 32'(exp_fun[got]));
        checkOutput("drain_carry", 32'(res_carry), 32'd0);
        got++;
      end
      tick();
    end
    checkOutput("drain_count", 32'(got), 32'd5);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (res_valid) extra++;
      tick();
    end
    checkOutput("refused_not_issued", 32'(extra), 32'd0);
    checkOutput("drain_ready", 32'(cmd_ready), 32'd1);

    applyStimulus(1'b1, 16'b1010, 16'b1111, 4'b0111);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
    waitResult(20);
    checkOutput("nor_seen", 32'(res_valid), 32'd1);
    checkOutput("nor_data", res_data, 32'h0000FFF0);
    checkOutput("nor_carry", 32'(res_carry), 32'd0);
    checkOutput("nor_fun", 32'(res_fun), 32'h7);
    tick();

`ifdef ALU_ISSUER_ERRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    force_logic_flag = 1'b1;
    applyStimulus(1'b1, 16'd1, 16'd2, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
    waitResult(20);
    checkOutput("err_seen", 32'(res_valid), 32'd1);
    checkOutput("err_data", res_data, 32'd3);
    checkOutput("err_flag", 32'(res_err), 32'(exp_err));
    force_logic_flag = 1'b0;
    tick();

    // Reset while the first of two queued commands is in ISSUE.
    applyStimulus(1'b1, 16'd3, 16'd4, 4'b0000);
    tick();
    applyStimulus(1'b1, 16'd5, 16'd6, 4'b0000);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0);
    checkOutput("pre_rst_issue_fun", 32'(alu_fun), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(res_valid), 32'd0);
    checkOutput("midrst_alu_fun", 32'(alu_fun), 32'h8);
    checkOutput("midrst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("midrst_ready", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid || alu_fun != 4'b1000) extra++;
    end
    checkOutput("post_rst_quiet", 32'(extra), 32'd0);
    checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
